// File: rtl/ptcalc_prod_accum.sv
// ptcalc_prod_accum
//   Accumulates signed 15x15 multiplier products into a 34-bit sum over one
//   pT frame. The frame ends on prod_tlast or on the NUM_TERMS-th product,
//   whichever comes first. The sum is then rounded (half-up), shifted right
//   by SHIFT, saturated to DOUT_WIDTH bits and held on the result port until
//   the downstream accepts it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   ACCUM  | accepting products, building the frame sum
//   HOLD   | result on pt_tdata/pt_terr, waiting for pt_tready
//
// Ports
//   ap_clk       in   clock, rising edge
//   ap_rst_n     in   asynchronous active-low reset
//   prod_tdata   in   [29:0] signed product
//   prod_tvalid  in   product valid
//   prod_tlast   in   last product of a frame
//   prod_tready  out  block accepts a product (ACCUM only)
//   pt_tdata     out  [DOUT_WIDTH-1:0] signed rounded, saturated pT
//   pt_terr      out  framing error: tlast and term count disagreed
//   pt_tvalid    out  result valid (HOLD only)
//   pt_tready    in   downstream accepts result
`timescale 1ns/1ps
module ptcalc_prod_accum #(
  parameter int NUM_TERMS  = 4,
  parameter int SHIFT      = 12,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [29:0]           prod_tdata,
  input  logic                  prod_tvalid,
  input  logic                  prod_tlast,
  output logic                  prod_tready,
  output logic [DOUT_WIDTH-1:0] pt_tdata,
  output logic                  pt_terr,
  output logic                  pt_tvalid,
  input  logic                  pt_tready
);

  localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TERMS - 1);

  // Rounding and saturation are done at 35 bits so the half-LSB add can
  // never wrap a full-scale 34-bit sum.
  localparam logic signed [34:0] RND     = 35'sd1 <<< (SHIFT - 1);
  localparam logic signed [34:0] SAT_MAX = (35'sd1 <<< (DOUT_WIDTH - 1)) - 35'sd1;
  localparam logic signed [34:0] SAT_MIN = -(35'sd1 <<< (DOUT_WIDTH - 1));

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [33:0]      acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DOUT_WIDTH-1:0]   pt_q, pt_d;
  logic                    err_q, err_d;
  logic                    en_q;

  logic                    accept;
  logic                    last_term;
  logic                    frame_end;
  logic signed [33:0]      sum;
  logic signed [34:0]      rnd;
  logic signed [34:0]      shifted;
  logic signed [34:0]      sat;

  // en_q holds prod_tready low while in reset and for the reset-release
  // cycle; it rises on the first clock edge after ap_rst_n deasserts.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  assign prod_tready = en_q & (state_q == ST_ACCUM);
  assign pt_tvalid   = (state_q == ST_HOLD);
  assign pt_tdata    = pt_q;
  assign pt_terr     = err_q;

  always_comb begin
    accept    = prod_tvalid & prod_tready;
    last_term = (cnt_q == LAST_CNT);
    frame_end = accept & (prod_tlast | last_term);

    sum     = acc_q + $signed({{4{prod_tdata[29]}}, prod_tdata});
    rnd     = $signed({sum[33], sum}) + RND;
    shifted = rnd >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = shifted;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    err_d   = err_q;

    case (state_q)
      ST_ACCUM: begin
        if (frame_end) begin
          pt_d    = sat[DOUT_WIDTH-1:0];
          err_d   = prod_tlast ^ last_term;
          state_d = ST_HOLD;
        end else if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (pt_tready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_ptcalc_prod_accum.sv
// Testbench for ptcalc_prod_accum: default instance (4 terms) plus a
// NUM_TERMS=1 instance. Directed frames and randomized frames are checked
// against an arithmetic reference model of the frame sum, rounding and
// saturation.
`timescale 1ns/1ps
module tb_ptcalc_prod_accum;

  localparam int NT = 4;
  localparam int SH = 12;
  localparam int DW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [29:0]   prod_tdata;
  logic          prod_tvalid;
  logic          prod_tlast;
  logic          prod_tready;
  logic [DW-1:0] pt_tdata;
  logic          pt_terr;
  logic          pt_tvalid;
  logic          pt_tready;

  logic [29:0]   d1_prod_tdata;
  logic          d1_prod_tvalid;
  logic          d1_prod_tlast;
  logic          d1_prod_tready;
  logic [DW-1:0] d1_pt_tdata;
  logic          d1_pt_terr;
  logic          d1_pt_tvalid;
  logic          d1_pt_tready;

  int n_chk = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  ptcalc_prod_accum #(.NUM_TERMS(NT), .SHIFT(SH), .DOUT_WIDTH(DW)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tlast  (prod_tlast),
    .prod_tready (prod_tready),
    .pt_tdata    (pt_tdata),
    .pt_terr     (pt_terr),
    .pt_tvalid   (pt_tvalid),
    .pt_tready   (pt_tready)
  );

  ptcalc_prod_accum #(.NUM_TERMS(1), .SHIFT(SH), .DOUT_WIDTH(DW)) dut1 (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .prod_tdata  (d1_prod_tdata),
    .prod_tvalid (d1_prod_tvalid),
    .prod_tlast  (d1_prod_tlast),
    .prod_tready (d1_prod_tready),
    .pt_tdata    (d1_pt_tdata),
    .pt_terr     (d1_pt_terr),
    .pt_tvalid   (d1_pt_tvalid),
    .pt_tready   (d1_pt_tready)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum, half-up rounding, arithmetic shift, clamp.
  function automatic longint model_pt(input longint q[$], input int shift, input int dw);
    longint s, r, hi, lo;
    s = 0;
    foreach (q[i]) s += q[i];
    r  = (s + (longint'(1) <<< (shift - 1))) >>> shift;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic longint rand_prod();
    int r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return longint'(r >>> 2);
      1:       return longint'(r >>> 12);
      default: return longint'(r >>> 18);
    endcase
  endfunction

  // Called just after a rising edge. Optional idle cycles carry garbage
  // data/tlast with valid low, which the block must ignore.
  task automatic push(input longint d, input bit last, input int gaps);
    int n;
    for (int g = 0; g < gaps; g++) begin
      prod_tvalid = 1'b0;
      prod_tdata  = 30'($urandom);
      prod_tlast  = 1'($urandom);
      @(posedge ap_clk);
      #1;
    end
    prod_tvalid = 1'b1;
    prod_tdata  = d[29:0];
    prod_tlast  = last;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (prod_tready) begin
        @(posedge ap_clk);
        #1;
        break;
      end
      n++;
      if (n > 50) begin
        check("push_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_frame(input longint q[$], input bit last, input bit gaps_on);
    for (int i = 0; i < q.size(); i++) begin
      push(q[i], last && (i == q.size() - 1), gaps_on ? int'($urandom_range(0, 2)) : 0);
    end
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
  endtask

  // Called just after the edge that accepted the final product.
  task automatic collect(input longint exp_d, input longint exp_e, input int hold, input string tag);
    longint held;
    int     n;
    @(negedge ap_clk);
    check({tag, "_latency"}, longint'(pt_tvalid), 1);
    n = 0;
    while (!pt_tvalid && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!pt_tvalid) begin
      check({tag, "_valid_timeout"}, 0, 1);
      return;
    end
    check({tag, "_data"}, longint'($signed(pt_tdata)), exp_d);
    check({tag, "_terr"}, longint'(pt_terr), exp_e);
    held = longint'($signed(pt_tdata));
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      check({tag, "_hold_data"}, longint'($signed(pt_tdata)), held);
      check({tag, "_hold_terr"}, longint'(pt_terr), exp_e);
      check({tag, "_hold_ready"}, longint'(prod_tready), 0);
      check({tag, "_hold_valid"}, longint'(pt_tvalid), 1);
    end
    pt_tready = 1'b1;
    @(negedge ap_clk);
    pt_tready = 1'b0;
    check({tag, "_ready_back"}, longint'(prod_tready), 1);
    check({tag, "_valid_drop"}, longint'(pt_tvalid), 0);
    @(posedge ap_clk);
    #1;
  endtask

  // NUM_TERMS=1 instance: one product, one frame.
  task automatic push1(input longint d, input bit last, input string tag);
    d1_prod_tvalid = 1'b1;
    d1_prod_tdata  = d[29:0];
    d1_prod_tlast  = last;
    @(negedge ap_clk);
    check({tag, "_ready"}, longint'(d1_prod_tready), 1);
    @(posedge ap_clk);
    #1;
    d1_prod_tvalid = 1'b0;
    d1_prod_tlast  = 1'b0;
    @(negedge ap_clk);
    check({tag, "_valid"}, longint'(d1_pt_tvalid), 1);
    check({tag, "_data"}, longint'($signed(d1_pt_tdata)), model_pt('{d}, SH, DW));
    check({tag, "_terr"}, longint'(d1_pt_terr), last ? 0 : 1);
    d1_pt_tready = 1'b1;
    @(negedge ap_clk);
    d1_pt_tready = 1'b0;
    check({tag, "_ready_back"}, longint'(d1_prod_tready), 1);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint q[$];
    longint d;
    bit     last;
    int     len;

    ap_rst_n       = 1'b0;
    prod_tdata     = '0;
    prod_tvalid    = 1'b0;
    prod_tlast     = 1'b0;
    pt_tready      = 1'b0;
    d1_prod_tdata  = '0;
    d1_prod_tvalid = 1'b0;
    d1_prod_tlast  = 1'b0;
    d1_pt_tready   = 1'b0;

    #23;
    check("rst_tdata", longint'(pt_tdata), 0);
    check("rst_terr", longint'(pt_terr), 0);
    check("rst_tvalid", longint'(pt_tvalid), 0);
    check("rst_ready", longint'(prod_tready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    check("ready_before_edge", longint'(prod_tready), 0);
    @(negedge ap_clk);
    check("ready_after_edge", longint'(prod_tready), 1);
    check("d1_ready_after_edge", longint'(d1_prod_tready), 1);
    @(posedge ap_clk);
    #1;

    q = '{4096, 8192, -4096, 2048};
    send_frame(q, 1'b1, 1'b0);
    collect(3, 0, 0, "basic");

    q = '{1 << 28, 1 << 28, 1 << 28, 1 << 28};
    send_frame(q, 1'b1, 1'b0);
    collect(32767, 0, 0, "sat_pos");

    q = '{-(1 << 29), -(1 << 29), -(1 << 29), -(1 << 29)};
    send_frame(q, 1'b1, 1'b0);
    collect(-32768, 0, 0, "sat_neg");

    q = '{4096, 4096};
    send_frame(q, 1'b1, 1'b0);
    collect(2, 1, 0, "early_tlast");

    q = '{0, 0, 0, 0};
    send_frame(q, 1'b0, 1'b0);
    collect(0, 1, 0, "no_tlast");

    q = '{12288, 4096, 0, 4096};
    send_frame(q, 1'b1, 1'b1);
    collect(5, 0, 3, "hold3");

    // Reset mid-frame: partial sum must be discarded.
    push(100000, 1'b0, 0);
    push(200000, 1'b0, 0);
    prod_tvalid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_ready", longint'(prod_tready), 0);
    check("midrst_tvalid", longint'(pt_tvalid), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    q = '{4096, 4096, 4096, 4096};
    send_frame(q, 1'b1, 1'b0);
    collect(4, 0, 0, "after_midrst");

    // Reset in HOLD: pending result dropped.
    q = '{1 << 20, 1 << 20};
    send_frame(q, 1'b1, 1'b0);
    @(negedge ap_clk);
    check("holdrst_pre_valid", longint'(pt_tvalid), 1);
    ap_rst_n = 1'b0;
    #1;
    check("holdrst_valid", longint'(pt_tvalid), 0);
    check("holdrst_data", longint'(pt_tdata), 0);
    check("holdrst_terr", longint'(pt_terr), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    q = '{4096};
    send_frame(q, 1'b1, 1'b0);
    collect(1, 1, 0, "after_holdrst");

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, NT);
      last = (len < NT) ? 1'b1 : 1'($urandom);
      q.delete();
      for (int i = 0; i < len; i++) begin
        d = rand_prod();
        q.push_back(d);
      end
      send_frame(q, last, 1'b1);
      collect(model_pt(q, SH, DW), (last != (len == NT)) ? 1 : 0,
              int'($urandom_range(0, 3)), $sformatf("rand%0d", f));
    end

    push1(-2048, 1'b1, "nt1_neg");
    push1(-2049, 1'b1, "nt1_round");
    for (int f = 0; f < 6; f++) begin
      d = rand_prod();
      push1(d, 1'($urandom), $sformatf("nt1_rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
